// File: rtl/dds_pkg.sv
// Shared constants and FSM state encoding for the DDS sequencer.
// Imported by dds_phase_acc and dds_seq_ctrl.
package dds_pkg;

    localparam int ACC_W      = 32;
    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 10;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator: synchronous load, enable-gated add, wrap carry.
// Ports: clk, rst, i_load/i_load_val, i_en, i_ftw, o_addr_nxt, o_carry.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int ACC_W = dds_pkg::ACC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ACC_W-1:0]      i_load_val,
    input  logic                  i_en,
    input  logic [ACC_W-1:0]      i_ftw,
    output logic [ROM_ADDR_W-1:0] o_addr_nxt,
    output logic                  o_carry
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    assign w_sum      = {1'b0, r_acc} + {1'b0, i_ftw};
    assign o_carry    = w_sum[ACC_W];
    // Address of the sample that follows the current one.
    assign o_addr_nxt = w_sum[ACC_W-1 -: ROM_ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_en) begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/dds_seq_ctrl.sv
// DDS sequencer: config shadowing, run FSM, period counting, ROM
// addressing and output-valid alignment to the 1-cycle ROM latency.
// Ports: clk/rst, cfg_* handshake, start/stop, busy/done,
// rom_en/rom_addr/rom_q to the cosine ROM, dout/dout_valid.
module dds_seq_ctrl #(
    parameter int ACC_W = dds_pkg::ACC_W,
    parameter int CNT_W = dds_pkg::CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [ACC_W-1:0]               cfg_ftw,
    input  logic [dds_pkg::ROM_ADDR_W-1:0] cfg_phase,
    input  logic [CNT_W-1:0]               cfg_periods,
    input  logic                           start,
    input  logic                           stop,
    output logic                           busy,
    output logic                           done,
    output logic                           rom_en,
    output logic [dds_pkg::ROM_ADDR_W-1:0] rom_addr,
    input  logic [dds_pkg::ROM_DATA_W-1:0] rom_q,
    output logic [dds_pkg::ROM_DATA_W-1:0] dout,
    output logic                           dout_valid
);

    import dds_pkg::*;

    state_t r_state;
    state_t w_state_nxt;

    logic [ACC_W-1:0]      r_ftw;
    logic [ROM_ADDR_W-1:0] r_phase;
    logic [CNT_W-1:0]      r_periods;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rom_en;
    logic [ROM_ADDR_W-1:0] r_rom_addr;
    logic                  r_dout_valid;

    logic                  w_cfg_hs;
    logic [ROM_ADDR_W-1:0] w_start_phase;
    logic [ACC_W-1:0]      w_load_val;
    logic                  w_load;
    logic                  w_run;
    logic                  w_last;
    logic                  w_carry;
    logic [ROM_ADDR_W-1:0] w_addr_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_wrap_end;

    assign w_cfg_hs = cfg_valid & cfg_ready;

    // A config offered together with start takes effect for that run.
    assign w_start_phase = w_cfg_hs ? cfg_phase : r_phase;
    assign w_load_val    = {w_start_phase, {(ACC_W-ROM_ADDR_W){1'b0}}};

    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_wrap_end = w_carry && (r_periods != '0)
                        && (w_cnt_inc == r_periods);

    dds_phase_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_run),
        .i_ftw      (r_ftw),
        .o_addr_nxt (w_addr_nxt),
        .o_carry    (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        w_load      = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
                // Sample issued this cycle is the final one.
                if (stop || w_wrap_end) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ftw        <= '0;
            r_phase      <= '0;
            r_periods    <= '0;
            r_cnt        <= '0;
            r_rom_en     <= 1'b0;
            r_rom_addr   <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_cfg_hs) begin
                r_ftw     <= cfg_ftw;
                r_phase   <= cfg_phase;
                r_periods <= cfg_periods;
            end
            if (w_load) begin
                r_cnt      <= '0;
                r_rom_en   <= 1'b1;
                r_rom_addr <= w_start_phase;
            end else if (w_run) begin
                if (w_carry) begin
                    r_cnt <= w_cnt_inc;
                end
                if (w_last) begin
                    r_rom_en   <= 1'b0;
                    r_rom_addr <= '0;
                end else begin
                    r_rom_en   <= 1'b1;
                    r_rom_addr <= w_addr_nxt;
                end
            end
            r_dout_valid <= r_rom_en;
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign rom_en     = r_rom_en;
    assign rom_addr   = r_rom_addr;
    assign dout       = rom_q;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Randomized self-checking bench for dds_seq_ctrl with a stand-in ROM.
// Expected streams come from the closed-form sample/period arithmetic.
module tb_dds_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_ftw;
    logic [7:0]  cfg_phase;
    logic [15:0] cfg_periods;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [9:0]  rom_q = 10'd0;
    logic [9:0]  dout;
    logic        dout_valid;

    int          n_checks = 0;
    int          n_errs   = 0;

    logic [31:0] m_ftw;
    logic [7:0]  m_ph;
    logic [15:0] m_per;

    always #5 clk = ~clk;

    dds_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ftw     (cfg_ftw),
        .cfg_phase   (cfg_phase),
        .cfg_periods (cfg_periods),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .dout        (dout),
        .dout_valid  (dout_valid)
    );

    function automatic logic [9:0] rom_f(logic [7:0] a);
        return {a[1:0], a} ^ 10'h2A5;
    endfunction

    // Stand-in ROM: registered, zero when disabled.
    always @(posedge clk) begin
        rom_q <= rom_en ? rom_f(rom_addr) : 10'd0;
    end

    function automatic logic [7:0] m_addr(logic [31:0] f, logic [7:0] p,
                                          int k);
        logic [63:0] v;
        v = {32'h0, p, 24'h0} + 64'(k) * {32'h0, f};
        return v[31:24];
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge back in IDLE.
    // s = RUN cycle in which stop is raised (0 = none).
    task automatic run(input bit use_cfg, input logic [31:0] f,
                       input logic [7:0] p, input logic [15:0] per,
                       input int s, input bit junk);
        int          n;
        logic [63:0] num;
        if (use_cfg) begin
            cfg_valid   = 1'b1;
            cfg_ftw     = f;
            cfg_phase   = p;
            cfg_periods = per;
            m_ftw       = f;
            m_ph        = p;
            m_per       = per;
        end
        chk("idle_ready", 32'(cfg_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        if (m_per == 16'd0 || m_ftw == 32'd0) begin
            n = s;
        end else begin
            num = ({48'h0, m_per} << 32) - ({56'h0, m_ph} << 24);
            n = int'((num + {32'h0, m_ftw} - 64'd1) / {32'h0, m_ftw});
            if (s > 0 && s < n) n = s;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        for (int c = 1; c <= n + 2; c++) begin
            chk("rom_en", 32'(rom_en), 32'(c <= n));
            chk("rom_addr", 32'(rom_addr),
                (c <= n) ? 32'(m_addr(m_ftw, m_ph, c - 1)) : 32'd0);
            chk("dout_valid", 32'(dout_valid), 32'(c >= 2 && c <= n + 1));
            if (c >= 2 && c <= n + 1)
                chk("dout", 32'(dout),
                    32'(rom_f(m_addr(m_ftw, m_ph, c - 2))));
            chk("done", 32'(done), 32'(c == n + 1));
            chk("busy", 32'(busy), 32'(c <= n + 1));
            chk("cfg_ready", 32'(cfg_ready), 32'(c > n + 1));
            stop = (c == s) && (c <= n);
            if (junk && c <= n) begin
                cfg_valid   = 1'($urandom);
                cfg_ftw     = $urandom;
                cfg_phase   = 8'($urandom);
                cfg_periods = 16'($urandom);
                start       = 1'($urandom);
            end else begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
            if (c < n + 2) @(negedge clk);
        end
        stop      = 1'b0;
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        logic [31:0] f;
        logic [7:0]  p;
        logic [15:0] per;
        int          s;
        bit          uc;

        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_ftw     = 32'd0;
        cfg_phase   = 8'd0;
        cfg_periods = 16'd0;
        start       = 1'b0;
        stop        = 1'b0;
        m_ftw       = 32'd0;
        m_ph        = 8'd0;
        m_per       = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        stop = 1'b1;
        @(negedge clk);
        chk("idle_stop_busy", 32'(busy), 32'd0);
        stop = 1'b0;

        run(1'b1, 32'h0100_0000, 8'h00, 16'd1, 0, 1'b0);
        run(1'b1, 32'h4000_0000, 8'h40, 16'd3, 0, 1'b1);
        run(1'b0, 32'd0, 8'd0, 16'd0, 0, 1'b0);
        run(1'b1, 32'h4000_0000, 8'h40, 16'd3, 11, 1'b0);
        run(1'b1, 32'h0080_0000, 8'h00, 16'd0, 10, 1'b0);

        // Config-only handshake, then a run on the stored values.
        cfg_valid   = 1'b1;
        cfg_ftw     = 32'h2300_0000;
        cfg_phase   = 8'hF0;
        cfg_periods = 16'd2;
        chk("cfg_only_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        m_ftw     = 32'h2300_0000;
        m_ph      = 8'hF0;
        m_per     = 16'd2;
        chk("cfg_only_busy", 32'(busy), 32'd0);
        run(1'b0, 32'd0, 8'd0, 16'd0, 0, 1'b1);

        for (int i = 0; i < 14; i++) begin
            per = 16'($urandom_range(0, 4));
            f   = $urandom;
            if (f < 32'h0200_0000) f = f + 32'h0200_0000;
            p   = 8'($urandom);
            uc  = ($urandom_range(0, 3) != 0);
            if (per == 16'd0) s = $urandom_range(1, 40);
            else if ($urandom_range(0, 2) == 0) s = $urandom_range(1, 50);
            else s = 0;
            if (!uc && m_per == 16'd0 && s == 0) s = 20;
            run(uc, f, p, per, s, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a continuous run.
        cfg_valid   = 1'b1;
        cfg_ftw     = 32'h0123_4567;
        cfg_phase   = 8'h3C;
        cfg_periods = 16'd0;
        start       = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rom_en", 32'(rom_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
        rst   = 1'b0;
        m_ftw = 32'd0;
        m_ph  = 8'd0;
        m_per = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        run(1'b0, 32'd0, 8'd0, 16'd0, 8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/dds_seq_ctrl.md
Name: dds_seq_ctrl

Overview:
Phase-accumulator sequencer that drives the quarter-wave cosine ROM (rom_cos: en, addr[7:0], 1-cycle registered q[9:0], q=0 when en low).
- Accepts a configuration: frequency tuning word, start phase and number of output periods.
- On start, it runs the accumulator, issues one ROM address per clock and counts full waveform periods.
- It stops on count exhaustion or explicit stop, and aligns an output-valid flag to the ROM latency.
- Sits between the register/control interface and the ROM in the DDS datapath.

Parameters:
ACC_W, 32, phase accumulator width; ROM address = acc[ACC_W-1 -: 8]
CNT_W, 16, period counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted when cfg_valid&cfg_ready
cfg_ftw  in  ACC_W  frequency tuning word
cfg_phase  in  8  start phase (ROM address units)
cfg_periods  in  CNT_W  periods to generate; 0 = continuous
start  in  1  begin generation (level sampled per cycle)
stop  in  1  abort generation
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
rom_en  out  1  ROM enable
rom_addr  out  8  ROM address
rom_q  in  10  ROM data (1-cycle latency)
dout  out  10  sample, equals rom_q
dout_valid  out  1  dout holds a valid sample

Behaviour:
- Reset (synchronous, any state):
  - Outputs: state=IDLE, acc=0, period count=0, rom_en=0, dout_valid=0, done=0, busy=0.
  - Shadow registers: ftw=0, phase=0, periods=0.
  - An in-flight run is discarded with no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_ready=1. A handshake loads cfg_ftw, cfg_phase and cfg_periods into the shadow registers.
  - start=1 → acc <= {phase,0...}, count <= 0, state → RUN.
  - start and cfg handshake in the same cycle: the run uses the incoming cfg values.
  - stop is ignored.
- RUN:
  - cfg_ready=0; cfg_valid is ignored.
  - Each cycle: rom_en=1, rom_addr=acc[ACC_W-1 -: 8], acc <= acc + ftw (mod 2^ACC_W).
  - A carry out of that addition is one completed period: count <= count+1.
  - If periods!=0 and the carry makes count+1 == periods → DRAIN. The address issued in that cycle is the last sample.
  - stop=1 → DRAIN. The address issued in the stop cycle is still valid and is the last sample.
  - stop coinciding with the final wrap → a single DRAIN and a single done.
  - start is ignored.
  - ftw=0 never wraps; only stop or rst terminates the run.
- DRAIN (one cycle): rom_en=0, done=1 (last sample is visible on dout this cycle) → IDLE.
- rom_addr is a registered output; in IDLE and DRAIN it holds 0.
- dout_valid <= rom_en (1-cycle delay), reset 0. dout = rom_q combinationally.
- Latency: start sampled at edge N → first rom_addr valid in cycle N+1 → first dout_valid in cycle N+2.
- Sample k address = (phase·2^(ACC_W-8) + k·ftw) >> (ACC_W-8), mod 256.
- busy is high from the cycle after start through DRAIN inclusive.

Decomposition:
- Shared package dds_pkg: ACC_W, ROM_ADDR_W=8, ROM_DATA_W=10, CNT_W, state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
- One natural sub-module: dds_phase_acc.
  - Registered accumulator with synchronous load of the start phase, enable-gated add and a carry (wrap) output.
  - dds_seq_ctrl holds the FSM, the shadow registers, the period counter and valid alignment.
- rom_cos stays outside; it is connected at the top level.

Test Plan:
1. Assert rst for 2 cycles, then release with all inputs 0 → rom_en=0, dout_valid=0, done=0, busy=0, cfg_ready=1.
2. cfg ftw=0x01000000, phase=0, periods=1; start pulse → rom_addr 0,1,…,255 on 256 consecutive cycles; dout_valid high 256 cycles, lagging rom_en by 1; one done pulse aligned with the last dout_valid; busy falls the cycle after.
3. ftw=0x40000000, phase=0x40, periods=3 → addresses 40,80,C0,00,40,80,C0,00,40,80,C0 (11 samples), then DRAIN, done once.
4. periods=0, ftw=0x00800000, phase=0; start, then stop on the 10th RUN cycle → addresses 0,0,1,1,2,2,3,3,4,4 and no more; done once.
5. cfg_valid with a new ftw during RUN → cfg_ready=0, old ftw still used, next run unchanged. cfg_valid+start in the same IDLE cycle → the run uses the new ftw from its first increment.
6. rst asserted mid-RUN → next cycle rom_en=0, busy=0, done never pulses. A subsequent start with no cfg uses ftw=0, so the address stays at 0 until stop.
